// File: rtl/wb_arb_pkg.sv
// Shared writeback-arbiter definitions: source indices, default widths, pointer helper.
// XLEN defaults to 32 unless MYRISCV_XLEN is supplied by the build.
`ifndef MYRISCV_XLEN
`define MYRISCV_XLEN 32
`endif

package wb_arb_pkg;

    typedef enum logic [1:0] {
        WB_SRC_ALU    = 2'd0,
        WB_SRC_LSU    = 2'd1,
        WB_SRC_MULDIV = 2'd2,
        WB_SRC_CSR    = 2'd3
    } wb_src_e;

    localparam int WB_NSRC  = 4;
    localparam int WB_RAW   = 5;
    localparam int WB_XLEN  = `MYRISCV_XLEN;
    localparam int WB_CNT_W = 32;

    // Round-robin successor of the granted source, wrapping at n.
    function automatic int wb_next_ptr(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// Round-robin picker: first set req bit at or after ptr (wrapping) wins, one-hot gnt.
// Latency: combinational. Backpressure: none, pure function of req and ptr.
// Priority rotation itself is owned by the caller through ptr.
module wb_rr_arb #(
    parameter int NSRC = 4,
    parameter int PW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NSRC-1:0] gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NSRC; k++) begin
            idx = (int'(ptr) + k) % NSRC;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arb.sv
// Writeback arbiter: round-robin grant of one exu result per cycle into the regfile port; optional MYRISCV_WBARB_PERF_EN stall counters.
// Latency: grant in cycle N -> rf_wen/rf_waddr/rf_wdata (and forwarding copy) valid in N+1 for one cycle.
// Backpressure: regfile always accepts, so some source is granted every cycle any src_vld is high; losers wait.
module wb_arb
    import wb_arb_pkg::*;
#(
    parameter int NSRC = WB_NSRC,
    parameter int XLEN = WB_XLEN,
    parameter int RAW  = WB_RAW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC-1:0]      src_vld,
    output logic [NSRC-1:0]      src_rdy,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic [NSRC*RAW-1:0]  src_rdidx,
    output logic                 rf_wen,
    output logic [RAW-1:0]       rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 fwd_vld,
    output logic [RAW-1:0]       fwd_idx,
    output logic [XLEN-1:0]      fwd_data
`ifdef MYRISCV_WBARB_PERF_EN
    ,
    output logic [NSRC*WB_CNT_W-1:0] perf_stall_cnt
`endif
);

    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rf_wen_q, rf_wen_d;
    logic [RAW-1:0]  rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [NSRC-1:0] gnt;
    logic [RAW-1:0]  sel_idx;
    logic [XLEN-1:0] sel_data;
    logic            any_gnt;

    wb_rr_arb #(
        .NSRC (NSRC),
        .PW   (PW)
    ) u_rr (
        .req (src_vld),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // No handshakes may complete while reset holds the pipeline.
    assign src_rdy = gnt & {NSRC{rst}};

    always_comb begin
        ptr_d    = ptr_q;
        sel_idx  = '0;
        sel_data = '0;
        any_gnt  = |src_rdy;
        for (int i = 0; i < NSRC; i++) begin
            if (src_rdy[i]) begin
                sel_idx  = src_rdidx[i*RAW +: RAW];
                sel_data = src_data[i*XLEN +: XLEN];
                ptr_d    = PW'(wb_next_ptr(i, NSRC));
            end
        end
        rf_wen_d   = any_gnt && (sel_idx != '0);
        rf_waddr_d = any_gnt ? sel_idx  : rf_waddr_q;
        rf_wdata_d = any_gnt ? sel_data : rf_wdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign fwd_vld  = rf_wen_q;
    assign fwd_idx  = rf_waddr_q;
    assign fwd_data = rf_wdata_q;

`ifdef MYRISCV_WBARB_PERF_EN
    logic [WB_CNT_W-1:0] cnt_q [NSRC];
    logic [WB_CNT_W-1:0] cnt_d [NSRC];

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (src_vld[i] && !src_rdy[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        perf_stall_cnt = '0;
        for (int i = 0; i < NSRC; i++) begin
            perf_stall_cnt[i*WB_CNT_W +: WB_CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: reset state, single source, rotation, x0 drop, mid-run reset, optional stall counters.
module tb_wb_arb;
    import wb_arb_pkg::*;

    localparam int NSRC = WB_NSRC;
    localparam int XLEN = WB_XLEN;
    localparam int RAW  = WB_RAW;
    localparam int NVEC = 13;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NSRC-1:0]      src_vld;
    logic [NSRC-1:0]      src_rdy;
    logic [NSRC*XLEN-1:0] src_data;
    logic [NSRC*RAW-1:0]  src_rdidx;
    logic                 rf_wen;
    logic [RAW-1:0]       rf_waddr;
    logic [XLEN-1:0]      rf_wdata;
    logic                 fwd_vld;
    logic [RAW-1:0]       fwd_idx;
    logic [XLEN-1:0]      fwd_data;
`ifdef MYRISCV_WBARB_PERF_EN
    logic [NSRC*WB_CNT_W-1:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NSRC-1:0] vld;
        logic [RAW-1:0]  rd;
        logic [NSRC-1:0] exp_rdy;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    wb_arb u_dut (
        .clk       (clk),
        .rst       (rst),
        .src_vld   (src_vld),
        .src_rdy   (src_rdy),
        .src_data  (src_data),
        .src_rdidx (src_rdidx),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .fwd_vld   (fwd_vld),
        .fwd_idx   (fwd_idx),
        .fwd_data  (fwd_data)
`ifdef MYRISCV_WBARB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_src();
        src_vld   = '0;
        src_data  = '0;
        src_rdidx = '0;
    endtask

    task automatic set_src(input int i, input logic [XLEN-1:0] d, input logic [RAW-1:0] rd);
        src_vld[i]                 = 1'b1;
        src_data[i*XLEN +: XLEN]   = d;
        src_rdidx[i*RAW +: RAW]    = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] vec_data(input logic [RAW-1:0] rd, input int i);
        return XLEN'(int'(rd) * 65536 + 256 + i);
    endfunction

    logic [RAW-1:0]  last_waddr;
    logic [XLEN-1:0] last_wdata;
    logic            hold_ok;
    logic            exp_wen;
    logic [XLEN-1:0] exp_data;
    int              g;

    initial begin
        // Starting pointer is 3 after the single-MULDIV sequence.
        vecs[0]  = '{4'b1111, 5'd7,  4'b1000};
        vecs[1]  = '{4'b1111, 5'd7,  4'b0001};
        vecs[2]  = '{4'b1111, 5'd7,  4'b0010};
        vecs[3]  = '{4'b1010, 5'd4,  4'b1000};
        vecs[4]  = '{4'b0010, 5'd4,  4'b0010};
        vecs[5]  = '{4'b0000, 5'd0,  4'b0000};
        vecs[6]  = '{4'b0001, 5'd0,  4'b0001};
        vecs[7]  = '{4'b0001, 5'd9,  4'b0001};
        vecs[8]  = '{4'b1001, 5'd3,  4'b1000};
        vecs[9]  = '{4'b0001, 5'd3,  4'b0001};
        vecs[10] = '{4'b0100, 5'd31, 4'b0100};
        vecs[11] = '{4'b0011, 5'd12, 4'b0001};
        vecs[12] = '{4'b0011, 5'd12, 4'b0010};

        rst = 1'b0;
        clear_src();
        src_vld = '1;
        #2;
        chk("reset_wen",   64'(rf_wen),   64'd0);
        chk("reset_waddr", 64'(rf_waddr), 64'd0);
        chk("reset_wdata", 64'(rf_wdata), 64'd0);
        chk("reset_fwd",   64'(fwd_vld),  64'd0);
        chk("reset_rdy",   64'(src_rdy),  64'd0);
        tick();
        chk("reset_wen_hold", 64'(rf_wen), 64'd0);
`ifdef MYRISCV_WBARB_PERF_EN
        chk("reset_perf", 64'(perf_stall_cnt[WB_CNT_W-1:0]), 64'd0);
`endif
        clear_src();
        rst = 1'b1;
        #1;

        // Single MULDIV request.
        set_src(int'(WB_SRC_MULDIV), XLEN'(32'h0000_0007), 5'd5);
        #1;
        chk("t1_rdy", 64'(src_rdy), 64'b0100);
        tick();
        chk("t1_wen",   64'(rf_wen),   64'd1);
        chk("t1_waddr", 64'(rf_waddr), 64'd5);
        chk("t1_wdata", 64'(rf_wdata), 64'd7);
        chk("t1_fwd",   64'(fwd_vld),  64'd1);
        chk("t1_fidx",  64'(fwd_idx),  64'd5);
        chk("t1_fdata", 64'(fwd_data), 64'd7);
        clear_src();
        tick();
        chk("t1_wen_drop", 64'(rf_wen), 64'd0);
        last_waddr = 5'd5;
        last_wdata = XLEN'(7);
        hold_ok    = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            clear_src();
            for (int i = 0; i < NSRC; i++) begin
                if (vecs[v].vld[i]) set_src(i, vec_data(vecs[v].rd, i), vecs[v].rd);
            end
            #1;
            chk($sformatf("v%0d_rdy", v), 64'(src_rdy), 64'(vecs[v].exp_rdy));
            g = -1;
            for (int i = 0; i < NSRC; i++) begin
                if (vecs[v].exp_rdy[i]) g = i;
            end
            tick();
            exp_wen  = (g >= 0) && (vecs[v].rd != '0);
            exp_data = (g >= 0) ? vec_data(vecs[v].rd, g) : '0;
            chk($sformatf("v%0d_wen", v), 64'(rf_wen),  64'(exp_wen));
            chk($sformatf("v%0d_fwd", v), 64'(fwd_vld), 64'(exp_wen));
            if (exp_wen) begin
                chk($sformatf("v%0d_waddr", v), 64'(rf_waddr), 64'(vecs[v].rd));
                chk($sformatf("v%0d_wdata", v), 64'(rf_wdata), 64'(exp_data));
                chk($sformatf("v%0d_fidx", v),  64'(fwd_idx),  64'(vecs[v].rd));
                chk($sformatf("v%0d_fdata", v), 64'(fwd_data), 64'(exp_data));
                last_waddr = vecs[v].rd;
                last_wdata = exp_data;
                hold_ok    = 1'b1;
            end else if (g < 0 && hold_ok) begin
                chk($sformatf("v%0d_waddr_hold", v), 64'(rf_waddr), 64'(last_waddr));
                chk($sformatf("v%0d_wdata_hold", v), 64'(rf_wdata), 64'(last_wdata));
            end else begin
                hold_ok = 1'b0;
            end
        end

        // All four valid continuously out of reset: strict 0,1,2,3 rotation.
        rst = 1'b0;
        clear_src();
        #2;
        for (int i = 0; i < NSRC; i++) set_src(i, XLEN'(32'hC0 + i), RAW'(i + 1));
        #1;
        chk("t2_rdy_in_reset", 64'(src_rdy), 64'd0);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("t2_c%0d_rdy", c), 64'(src_rdy), 64'(1 << (c % NSRC)));
            tick();
            chk($sformatf("t2_c%0d_wen", c),   64'(rf_wen),   64'd1);
            chk($sformatf("t2_c%0d_waddr", c), 64'(rf_waddr), 64'((c % NSRC) + 1));
            chk($sformatf("t2_c%0d_wdata", c), 64'(rf_wdata), 64'(32'hC0 + (c % NSRC)));
        end
`ifdef MYRISCV_WBARB_PERF_EN
        for (int i = 0; i < NSRC; i++) begin
            chk($sformatf("t6_perf%0d", i), 64'(perf_stall_cnt[i*WB_CNT_W +: WB_CNT_W]), 64'd6);
        end
`endif

        // Reset while a write is being presented.
        chk("t5_wen_before", 64'(rf_wen), 64'd1);
        rst = 1'b0;
        #1;
        chk("t5_wen_async", 64'(rf_wen),  64'd0);
        chk("t5_fwd_async", 64'(fwd_vld), 64'd0);
        chk("t5_rdy_async", 64'(src_rdy), 64'd0);
`ifdef MYRISCV_WBARB_PERF_EN
        chk("t5_perf_clr", 64'(perf_stall_cnt[WB_CNT_W-1:0]), 64'd0);
`endif
        clear_src();
        set_src(1, XLEN'(32'hDEAD_BEEF), 5'd10);
        set_src(2, XLEN'(32'h1234_5678), 5'd11);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rdy_after", 64'(src_rdy), 64'b0010);
        tick();
        chk("t5_wen",   64'(rf_wen),   64'd1);
        chk("t5_waddr", 64'(rf_waddr), 64'd10);
        chk("t5_wdata", 64'(rf_wdata), 64'(32'hDEAD_BEEF));
        src_vld[1] = 1'b0;
        #1;
        chk("t5_rdy_next", 64'(src_rdy), 64'b0100);
        tick();
        chk("t5_waddr2", 64'(rf_waddr), 64'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
